// File: rtl/timer_counter_if.sv
// timer_counter_if: register bus and interrupt between a CPU master and the timer
interface timer_counter_if;
  logic [1:0] addr;
  logic we;
  logic [31:0] din;
  logic [31:0] dout;
  logic irq;
  modport master(output addr, we, din, input dout, irq);
  modport slave(input addr, we, din, output dout, irq);
endinterface

// File: rtl/timer_counter.sv
// timer_counter: programmable down-counter with one-shot / auto-reload modes and a maskable irq
module timer_counter #(
  parameter logic [31:0] PRESET_INIT = 32'h0
) (
  input logic clk,
  input logic reset,
  timer_counter_if.slave bus
);
  typedef enum logic [1:0] {IDLE, LOAD, CNT, INT} state_t;
  state_t state, state_nxt;
  logic en, en_nxt, im, flag, flag_nxt;
  logic [1:0] mode;
  logic [31:0] preset, count, count_nxt;
  logic ctrl_wr, preset_wr, stop_wr;
  assign ctrl_wr = bus.we && bus.addr == 2'd0;
  assign preset_wr = bus.we && bus.addr == 2'd1;
  assign stop_wr = ctrl_wr && !bus.din[0];
  always_comb begin
    state_nxt = state;
    count_nxt = count;
    flag_nxt = flag && !(ctrl_wr || preset_wr);
    en_nxt = ctrl_wr ? bus.din[0] : en;
    // a disabling CTRL write freezes COUNT and parks the machine in IDLE
    if (stop_wr) begin
      state_nxt = IDLE;
      flag_nxt = 1'b0;
    end else begin
      case (state)
        IDLE: state_nxt = en ? LOAD : IDLE;
        LOAD: begin
          count_nxt = preset;
          state_nxt = CNT;
        end
        CNT:
          if (!en) state_nxt = IDLE;
          else if (count > 32'd1) count_nxt = count - 32'd1;
          else begin
            count_nxt = 32'd0;
            flag_nxt = 1'b1;
            state_nxt = INT;
          end
        INT:
          if (mode == 2'd1) begin
            flag_nxt = 1'b0;
            state_nxt = LOAD;
          end else begin
            en_nxt = ctrl_wr ? bus.din[0] : 1'b0;
            state_nxt = IDLE;
          end
      endcase
    end
  end
  always_ff @(posedge clk) begin
    if (!reset) begin
      state <= IDLE;
      en <= 1'b0;
      mode <= 2'd0;
      im <= 1'b0;
      flag <= 1'b0;
      count <= 32'd0;
      preset <= PRESET_INIT;
    end else begin
      state <= state_nxt;
      en <= en_nxt;
      flag <= flag_nxt;
      count <= count_nxt;
      if (ctrl_wr) begin
        mode <= bus.din[2:1];
        im <= bus.din[3];
      end
      if (preset_wr) preset <= bus.din;
    end
  end
  assign bus.dout = bus.addr == 2'd0 ? {28'd0, im, mode, en} :
                    bus.addr == 2'd1 ? preset :
                    bus.addr == 2'd2 ? count : 32'd0;
  assign bus.irq = flag & im;
endmodule

// File: tb/tb_timer_counter.sv
// tb_timer_counter: vector table, corner-case sequences and random traffic against a timeline model
module tb_timer_counter;
  logic clk = 1'b0;
  logic reset = 1'b0;
  timer_counter_if bus();
  timer_counter dut (.clk(clk), .reset(reset), .bus(bus));
  always #5 clk = ~clk;
  int errors = 0;
  int checks = 0;
  // model: age counts edges since the run left IDLE (1 = LOAD, 2.. = counting, pl+2 = expired)
  logic [31:0] m_preset, m_count, m_lp;
  logic m_en, m_im, m_flag;
  logic [1:0] m_mode;
  longint m_age;
  typedef struct {
    logic r;
    logic w;
    logic [1:0] a;
    logic [31:0] d;
    logic [31:0] exp_dout;
    logic exp_irq;
  } vec_t;
  vec_t tbl[13];
  task automatic chk(input string n, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h at %0t", n, got, exp, $time);
    end
  endtask
  function automatic logic [31:0] mread(input logic [1:0] a);
    return a == 2'd0 ? {28'd0, m_im, m_mode, m_en} : a == 2'd1 ? m_preset : a == 2'd2 ? m_count : 32'd0;
  endfunction
  task automatic model(input logic r, input logic w, input logic [1:0] a, input logic [31:0] d);
    logic cw, pw;
    longint pl;
    cw = w && a == 2'd0;
    pw = w && a == 2'd1;
    if (!r) begin
      m_preset = 32'h0; m_count = 0; m_lp = 0; m_en = 0; m_im = 0; m_flag = 0; m_mode = 0; m_age = 0;
      return;
    end
    pl = (m_lp == 0) ? 1 : longint'(m_lp);
    if (cw && !d[0]) begin
      m_age = 0;
      m_flag = 0;
    end else begin
      if (cw || pw) m_flag = 0;
      if (m_age == 0) begin
        if (m_en) m_age = 1;
      end else if (m_age == 1) begin
        m_lp = m_preset;
        m_count = m_preset;
        m_age = 2;
      end else if (m_age < pl + 2) begin
        if (!m_en) m_age = 0;
        else begin
          m_age++;
          if (m_age == pl + 2) begin
            m_count = 0;
            m_flag = 1;
          end else m_count = m_lp - 32'(m_age - 2);
        end
      end else if (m_mode == 2'd1) begin
        m_flag = 0;
        m_age = 1;
      end else begin
        m_en = 0;
        m_age = 0;
      end
    end
    if (cw) {m_im, m_mode, m_en} = d[3:0];
    if (pw) m_preset = d;
  endtask
  task automatic step(input logic r, input logic w, input logic [1:0] a, input logic [31:0] d);
    @(negedge clk);
    reset = r; bus.we = w; bus.addr = a; bus.din = d;
    @(posedge clk);
    model(r, w, a, d);
    #1;
    chk("dout_model", bus.dout, mread(a));
    chk("irq_model", {31'd0, bus.irq}, {31'd0, m_flag & m_im});
  endtask
  task automatic rd(input logic [1:0] a);
    step(1'b1, 1'b0, a, 32'd0);
  endtask
  task automatic wr(input logic [1:0] a, input logic [31:0] d);
    step(1'b1, 1'b1, a, d);
  endtask
  initial begin
    bus.we = 0; bus.addr = 0; bus.din = 0;
    step(0, 0, 0, 0);
    chk("reset_ctrl", bus.dout, 32'd0);
    chk("reset_irq", {31'd0, bus.irq}, 32'd0);
    rd(1); chk("reset_preset", bus.dout, 32'd0);
    rd(2); chk("reset_count", bus.dout, 32'd0);
    // one-shot PRESET=5, IM=1: CTRL write is e0
    tbl[0]  = '{1, 1, 1, 5, 5, 0};
    tbl[1]  = '{1, 1, 0, 9, 9, 0};
    tbl[2]  = '{1, 0, 2, 0, 0, 0};
    tbl[3]  = '{1, 0, 2, 0, 5, 0};
    tbl[4]  = '{1, 0, 2, 0, 4, 0};
    tbl[5]  = '{1, 0, 2, 0, 3, 0};
    tbl[6]  = '{1, 0, 2, 0, 2, 0};
    tbl[7]  = '{1, 0, 2, 0, 1, 0};
    tbl[8]  = '{1, 0, 2, 0, 0, 1};
    tbl[9]  = '{1, 0, 0, 0, 8, 1};
    tbl[10] = '{1, 0, 0, 0, 8, 1};
    tbl[11] = '{1, 1, 0, 8, 8, 0};
    tbl[12] = '{1, 1, 2, 77, 0, 0};
    foreach (tbl[i]) begin
      step(tbl[i].r, tbl[i].w, tbl[i].a, tbl[i].d);
      chk($sformatf("tbl%0d_dout", i), bus.dout, tbl[i].exp_dout);
      chk($sformatf("tbl%0d_irq", i), {31'd0, bus.irq}, {31'd0, tbl[i].exp_irq});
    end
    // auto-reload PRESET=3: one-cycle pulse every 5 cycles, reload to 3
    wr(1, 3); wr(0, 4'b1011);
    for (int i = 1; i <= 20; i++) begin
      rd(2);
      chk($sformatf("reload_irq_e%0d", i), {31'd0, bus.irq}, {31'd0, i >= 5 && (i - 5) % 5 == 0});
      if (i >= 5 && (i - 5) % 5 == 2) chk($sformatf("reload_cnt_e%0d", i), bus.dout, 32'd3);
    end
    wr(0, 0);
    // stop mid-count at COUNT=10
    wr(1, 20); wr(0, 9);
    for (int i = 1; i <= 12; i++) rd(2);
    chk("stop_pre_cnt", bus.dout, 32'd10);
    wr(0, 0); chk("stop_ctrl", bus.dout, 32'd0);
    for (int i = 0; i < 5; i++) begin
      rd(2);
      chk("stop_hold_cnt", bus.dout, 32'd10);
      chk("stop_irq", {31'd0, bus.irq}, 32'd0);
    end
    // IM=0 expiry, then CTRL=8 must not raise irq
    wr(1, 2); wr(0, 4'b0001);
    for (int i = 1; i <= 6; i++) begin
      rd(2);
      chk("masked_irq", {31'd0, bus.irq}, 32'd0);
    end
    wr(0, 4'b1000); chk("unmask_irq", {31'd0, bus.irq}, 32'd0);
    for (int i = 0; i < 3; i++) begin
      rd(0);
      chk("unmask_ctrl", bus.dout, 32'd8);
      chk("unmask_irq_hold", {31'd0, bus.irq}, 32'd0);
    end
    // reset while COUNT=2 with a write on the reset edge
    wr(1, 4); wr(0, 9);
    for (int i = 1; i <= 4; i++) rd(2);
    chk("pre_reset_cnt", bus.dout, 32'd2);
    step(0, 1, 1, 7); chk("reset_wr_discard", bus.dout, 32'd0);
    rd(0); chk("mid_reset_ctrl", bus.dout, 32'd0);
    for (int i = 0; i < 10; i++) begin
      rd(2);
      chk("post_reset_irq", {31'd0, bus.irq}, 32'd0);
      chk("post_reset_cnt", bus.dout, 32'd0);
    end
    // PRESET=0 behaves as 1; writes to COUNT and reserved ignored
    wr(1, 0); wr(0, 9);
    rd(2); rd(2); chk("p0_irq_e2", {31'd0, bus.irq}, 32'd0);
    rd(2); chk("p0_irq_e3", {31'd0, bus.irq}, 32'd1);
    wr(2, 123); chk("count_ro", bus.dout, 32'd0);
    wr(3, 5); chk("reserved_rd", bus.dout, 32'd0);
    wr(0, 0);
    // full-scale preset does not wrap
    wr(1, 32'hFFFF_FFFF); wr(0, 1);
    rd(2); rd(2); chk("max_load", bus.dout, 32'hFFFF_FFFF);
    rd(2); chk("max_dec", bus.dout, 32'hFFFF_FFFE);
    wr(0, 0);
    // Mode 2 behaves as one-shot
    wr(1, 1); wr(0, 4'b1101);
    rd(0); rd(0); rd(0); chk("mode2_irq", {31'd0, bus.irq}, 32'd1);
    rd(0); chk("mode2_en_clr", bus.dout, 32'hC);
    wr(0, 0);
    // random traffic against the model
    for (int i = 0; i < 3000; i++) begin
      logic r, w;
      logic [1:0] a;
      logic [31:0] d;
      r = $urandom_range(0, 99) != 0;
      w = $urandom_range(0, 7) == 0;
      a = 2'($urandom_range(0, 3));
      d = $urandom;
      if (a == 2'd1) d = $urandom_range(0, 6);
      if (a == 2'd0 && $urandom_range(0, 2) != 0) d[0] = 1'b1;
      step(r, w, a, d);
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/timer_counter.md
TIMER_COUNTER -- requirements
Module: timer_counter

Interface
REQ-001 The block SHALL have parameter PRESET_INIT, default 32'h0, giving the PRESET register reset value.
REQ-002 The block SHALL have port clk, input, 1, the single rising-edge clock.
REQ-003 The block SHALL have port reset, input, 1, synchronous active-low reset: sampled only on rising clk, and 0 means reset.
REQ-004 The block SHALL have port addr, input, 2, the register select: 0=CTRL, 1=PRESET, 2=COUNT, 3=reserved.
REQ-005 The block SHALL have port we, input, 1, the write strobe, sampled on rising clk.
REQ-006 The block SHALL have port din, input, 32, the write data.
REQ-007 The block SHALL have port dout, output, 32, combinational read data for addr.
REQ-008 The block SHALL have port irq, output, 1, the interrupt request feeding one bit of the exception unit's HWInt[7:2].

Function
REQ-009 CTRL SHALL hold bit 0 Enable, bits [2:1] Mode, and bit 3 IM; bits [31:4] SHALL be 0 on read and SHALL ignore writes.
REQ-010 Mode 0 SHALL be one-shot, Mode 1 SHALL be auto-reload, and Modes 2 and 3 SHALL behave as Mode 0.
REQ-011 COUNT SHALL be read-only, and writes to addr 2 or 3 SHALL have no effect.
REQ-012 dout SHALL return CTRL, PRESET or COUNT per addr, and SHALL return 0 for addr 3.
REQ-013 The state machine SHALL have exactly four states: IDLE, LOAD, CNT and INT.
REQ-014 IDLE: if Enable=1, the next state SHALL be LOAD; otherwise the block SHALL stay in IDLE.
REQ-015 LOAD: the block SHALL set COUNT<=PRESET, and the next state SHALL be CNT.
REQ-016 CNT: if Enable=0, the next state SHALL be IDLE with COUNT held.
REQ-017 CNT: if COUNT>1, the block SHALL set COUNT<=COUNT-1.
REQ-018 CNT: if COUNT<=1, the block SHALL set COUNT<=0 and flag<=1, and the next state SHALL be INT.
REQ-019 INT, Mode 0: the block SHALL clear Enable, and the next state SHALL be IDLE; flag SHALL stay 1 until a software write to CTRL or PRESET.
REQ-020 INT, Mode 1: the block SHALL clear flag at the next edge, and the next state SHALL be LOAD, giving a one-cycle flag pulse per period.
REQ-021 irq SHALL be the registered flag AND IM, with no combinational path from din or we.
REQ-022 A CTRL write with Enable=0 SHALL force the next state to IDLE from any state.
REQ-023 A PRESET write SHALL NOT restart counting; the new value SHALL take effect at the next LOAD.
REQ-024 When a CTRL write and the INT-state Enable clear fall on the same edge, the software-written Enable SHALL win.
REQ-025 COUNT arithmetic SHALL be unsigned 32-bit.
REQ-026 PRESET=0 SHALL behave as PRESET=1, and PRESET=32'hFFFFFFFF SHALL count with no wrap-around.
REQ-027 For Mode 0 with PRESET=P>=1, if the Enable write is captured at edge e0, irq SHALL first be high after edge e0+P+2 when IM=1.
REQ-028 For Mode 1 with PRESET=P>=1, the irq period SHALL be P+2 cycles.

Reset
REQ-029 With reset=0 at a rising edge, the block SHALL set CTRL=0, COUNT=0, PRESET=PRESET_INIT, flag=0, irq=0 and state=IDLE.
REQ-030 Reset asserted mid-count SHALL abort counting at that edge; pending irq SHALL drop, and no interrupt SHALL be generated afterwards until software re-enables.
REQ-031 Register writes during a reset edge SHALL be discarded.

Verification
REQ-032 Scenario: PRESET=5, then CTRL=4'b1001 (IM=1, Mode 0, Enable=1) captured at e0 -> COUNT=5 after e2 and 1 after e6; irq=1 after e7; CTRL[0]=0 after e8; irq stays 1 until a CTRL write.
REQ-033 Scenario: PRESET=3, CTRL=4'b1011 (Mode 1) -> irq pulses exactly one cycle high every 5 cycles, and COUNT reloads to 3 after each pulse.
REQ-034 Scenario: mid-count with COUNT=10, write CTRL=0 -> state IDLE next edge, COUNT holds 10, and irq stays 0.
REQ-035 Scenario: IM=0 with Mode 0 expiry -> flag set and irq=0; then write CTRL=4'b1000 -> irq stays 0 because the write clears flag.
REQ-036 Scenario: reset=0 for one edge while COUNT=2 in CNT with IM=1 -> all registers reset, and irq never asserts in the following 10 cycles.
REQ-037 Scenario: PRESET=0 with Mode 0 enabled at e0 -> irq high after e3; and a write to addr 2 -> COUNT is unchanged.
